// File: rtl/muldiv_seq_ctrl.sv
// RV32M multi-cycle sequencer: radix-2 shift-add multiply, restoring divide.
// Latency XLEN+1 cycles (1 for div-by-zero/overflow); stalls EX until the single-cycle out_valid strobe.
module muldiv_seq_ctrl #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]           state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [2:0]           op_q;
  logic [XLEN-1:0]      hi_q;
  logic [XLEN-1:0]      lo_q;
  logic [XLEN-1:0]      opnd_q;
  logic [XLEN-1:0]      result_q;
  logic                 neg_q;
  logic                 rem_neg_q;

  logic            accept;
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic            last_iter;

  assign accept    = (state_q == S_IDLE) && in_valid && !flush;
  assign is_div    = funct3[2];
  // mul (000) only needs the low half, which is sign-agnostic.
  assign a_signed  = is_div ? !funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
  assign b_signed  = is_div ? !funct3[0] : (funct3[1:0] == 2'b01);
  assign a_neg     = a_signed && src_a[XLEN-1];
  assign b_neg     = b_signed && src_b[XLEN-1];
  assign a_mag     = a_neg ? -src_a : src_a;
  assign b_mag     = b_neg ? -src_b : src_b;
  assign div_zero  = is_div && (src_b == '0);
  assign div_ovf   = is_div && !funct3[0] && (src_a == INT_MIN) && (&src_b);
  assign last_iter = (cnt_q == CNT_WIDTH'(XLEN-1));

  // One iteration of each datapath; hi/lo double as accumulator or remainder/quotient.
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN-1:0] div_diff;
  logic            div_ge;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_diff  = div_shift[XLEN-1:0] - opnd_q;

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   final_val;

  assign prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo_s  = neg_q ? -lo_q : lo_q;
  assign rem_s  = rem_neg_q ? -hi_q : hi_q;

  always_comb begin
    final_val = '0;
    case (op_q)
      3'b000:                 final_val = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_val = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_val = quo_s;
      default:                final_val = rem_s;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q  <= funct3;
            cnt_q <= '0;
            if (div_zero) begin
              hi_q      <= src_a;
              lo_q      <= '1;
              neg_q     <= 1'b0;
              rem_neg_q <= 1'b0;
              state_q   <= S_DONE;
            end else if (div_ovf) begin
              hi_q      <= '0;
              lo_q      <= INT_MIN;
              neg_q     <= 1'b0;
              rem_neg_q <= 1'b0;
              state_q   <= S_DONE;
            end else if (is_div) begin
              hi_q      <= '0;
              lo_q      <= a_mag;
              opnd_q    <= b_mag;
              neg_q     <= a_neg ^ b_neg;
              rem_neg_q <= a_neg;
              state_q   <= S_BUSY;
            end else begin
              hi_q      <= '0;
              lo_q      <= b_mag;
              opnd_q    <= a_mag;
              neg_q     <= a_neg ^ b_neg;
              rem_neg_q <= 1'b0;
              state_q   <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
            if (op_q[2]) begin
              hi_q <= div_ge ? div_diff : div_shift[XLEN-1:0];
              lo_q <= {lo_q[XLEN-2:0], div_ge};
            end else begin
              hi_q <= mul_sum[XLEN:1];
              lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
            end
            if (last_iter) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (!flush) result_q <= final_val;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign stall     = accept || (state_q == S_BUSY);
  assign out_valid = (state_q == S_DONE) && !flush;
  assign result    = (state_q == S_DONE) ? final_val : result_q;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed and random checks of muldiv_seq_ctrl against an arithmetic reference model.
module tb_muldiv_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        flush = 1'b0;
  logic        stall;
  logic        busy;
  logic        out_valid;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_res = 32'd0;

  muldiv_seq_ctrl #(.XLEN(32), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .funct3(funct3),
    .src_a(src_a), .src_b(src_b), .flush(flush), .stall(stall),
    .busy(busy), .out_valid(out_valid), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q;
    longint la, lb, lub, sp;
    logic [63:0] up;
    logic [63:0] spv;
    sa = a; sb = b;
    la = longint'(sa); lb = longint'(sb); lub = longint'({32'd0, b});
    case (f)
      3'd0: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
      3'd1: begin sp = la * lb; spv = sp; return spv[63:32]; end
      3'd2: begin sp = la * lub; spv = sp; return spv[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; return q;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa % sb; return q;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents an op in the next cycle and follows it until out_valid; in_valid stays high on return.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
    int lat;
    logic [31:0] exp_r;
    exp_r = model(f, a, b);
    @(posedge clk); #1;
    in_valid = 1'b1; funct3 = f; src_a = a; src_b = b;
    lat = 0;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) break;
      check($sformatf("%s stall@%0d", tag, lat), 32'(stall), 32'd1);
      lat++;
      if (lat > 80) break;
      @(posedge clk); #1;
      funct3 = 3'($urandom); src_a = $urandom; src_b = $urandom;
    end
    check($sformatf("%s latency", tag), 32'(lat), 32'(model_lat(f, a, b)));
    check($sformatf("%s result", tag), result, exp_r);
    check($sformatf("%s stall_done", tag), 32'(stall), 32'd0);
    last_res = exp_r;
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  logic [2:0]  d_f [11] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a [11] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                            32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b [11] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                            32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #20;
    check("reset stall", 32'(stall), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7x-3");
    go_idle();
    @(negedge clk);
    check("result_hold", result, last_res);
    check("idle busy", 32'(busy), 32'd0);

    for (int i = 0; i < 11; i++) begin
      do_op(d_f[i], d_a[i], d_b[i], $sformatf("directed%0d", i));
      go_idle();
    end

    // Back-to-back: second op presented in the IDLE cycle right after out_valid.
    do_op(3'd0, 32'd1234, 32'd5678, "b2b_first");
    do_op(3'd0, 32'hFFFF_FFFF, 32'd3, "b2b_second");
    go_idle();

    // Flush while idle: nothing accepted.
    @(posedge clk); #1;
    in_valid = 1'b1; flush = 1'b1; funct3 = 3'd0; src_a = 32'd3; src_b = 32'd4;
    @(negedge clk);
    check("flush_idle stall", 32'(stall), 32'd0);
    go_idle();
    @(negedge clk);
    check("flush_idle busy", 32'(busy), 32'd0);

    // Flush a divide at T+10.
    @(posedge clk); #1;
    in_valid = 1'b1; funct3 = 3'd4; src_a = 32'hFFFF_FFF9; src_b = 32'd2;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 10) flush = 1'b1;
      @(negedge clk);
      check($sformatf("flush_busy out_valid@%0d", k), 32'(out_valid), 32'd0);
    end
    check("flush_busy busy@10", 32'(busy), 32'd1);
    go_idle();
    @(negedge clk);
    check("flush_busy busy@11", 32'(busy), 32'd0);
    check("flush_busy out_valid@11", 32'(out_valid), 32'd0);
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, "after_flush_mul");
    go_idle();

    // Flush during the DONE cycle of a divide-by-zero.
    @(posedge clk); #1;
    in_valid = 1'b1; funct3 = 3'd5; src_a = 32'd5; src_b = 32'd0;
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    check("flush_done out_valid", 32'(out_valid), 32'd0);
    check("flush_done busy", 32'(busy), 32'd1);
    go_idle();
    @(negedge clk);
    check("flush_done idle", 32'(busy), 32'd0);

    // Asynchronous reset at T+5 of a multiply.
    @(posedge clk); #1;
    in_valid = 1'b1; funct3 = 3'd0; src_a = 32'd9; src_b = 32'd9;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    check("midop_reset stall", 32'(stall), 32'd0);
    check("midop_reset busy", 32'(busy), 32'd0);
    check("midop_reset out_valid", 32'(out_valid), 32'd0);
    check("midop_reset result", result, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    do_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, "after_reset_mulh");
    go_idle();

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom); ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 15);
        default: ;
      endcase
      do_op(rf, ra, rb, $sformatf("rand%0d_f%0d", i, rf));
      if ($urandom_range(0, 1) == 0) go_idle();
    end
    go_idle();
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
